// File: rtl/oscilloscope_pkg.sv
// Shared constants for the ADC sampler: FSM state encoding, control-word layout
// and result field positions.
package oscilloscope_pkg;

    localparam int SAMPLE_W = 12;
    localparam int CHAN_W   = 3;
    localparam int WORD_W   = 16;

    typedef logic [2:0] state_t;

    localparam state_t INIT_Q = 3'd0;
    localparam state_t INIT_F = 3'd1;
    localparam state_t IDLE   = 3'd2;
    localparam state_t QUIET  = 3'd3;
    localparam state_t FRAME  = 3'd4;
    localparam state_t DONE   = 3'd5;

    // Bits 13:12 and 3:0 are padding zeros; ADD=5 yields 16'h8BB0.
    localparam int CW_WRITE   = 15;
    localparam int CW_SEQ     = 14;
    localparam int CW_ADD_MSB = 11;
    localparam int CW_ADD_LSB = 9;
    localparam int CW_PM_MSB  = 8;
    localparam int CW_PM_LSB  = 7;
    localparam int CW_SHADOW  = 6;
    localparam int CW_RANGE   = 5;
    localparam int CW_CODING  = 4;

    localparam int RES_CHAN_MSB = 14;
    localparam int RES_CHAN_LSB = 12;

    function automatic logic [WORD_W-1:0] ctrl_word(input logic [CHAN_W-1:0] add,
                                                    input logic range_bit);
        logic [WORD_W-1:0] w;
        w                        = '0;
        w[CW_WRITE]              = 1'b1;
        w[CW_SEQ]                = 1'b0;
        w[CW_ADD_MSB:CW_ADD_LSB] = add;
        w[CW_PM_MSB:CW_PM_LSB]   = 2'b11;
        w[CW_SHADOW]             = 1'b0;
        w[CW_RANGE]              = range_bit;
        w[CW_CODING]             = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/adc_sampler_if.sv
// Bundle of run/channel controls, converter serial pins and the sample output.
interface adc_sampler_if;
    import oscilloscope_pkg::*;

    logic                run;
    logic [CHAN_W-1:0]   chan;
    logic                ADC_DOUT;
    logic                ADC_DIN;
    logic                ADC_CS_N;
    logic                ADC_SCLK;
    logic                sample_valid;
    logic [SAMPLE_W-1:0] sample_data;
    logic [CHAN_W-1:0]   sample_chan;
    logic                busy;

    modport slave (
        input  run, chan, ADC_DOUT,
        output ADC_DIN, ADC_CS_N, ADC_SCLK, sample_valid, sample_data, sample_chan, busy
    );

    modport master (
        output run, chan, ADC_DOUT,
        input  ADC_DIN, ADC_CS_N, ADC_SCLK, sample_valid, sample_data, sample_chan, busy
    );
endinterface

// File: rtl/adc_sampler.sv
// Serial ADC frame sequencer: two dummy frames after reset, then continuous 16-bit
// frames while run is high; one sample_valid pulse per frame, no backpressure.
module adc_sampler
    import oscilloscope_pkg::*;
#(
    parameter int unsigned SCLK_DIV  = 2,
    parameter int unsigned QUIET_CYC = 4,
    parameter bit          RANGE_BIT = 1'b1
) (
    input  logic          CLK,
    input  logic          reset,
    adc_sampler_if.slave  bus
);

    localparam logic [7:0] DIV_LAST   = 8'(SCLK_DIV - 1);
    localparam logic [7:0] QUIET_LAST = 8'(QUIET_CYC - 1);

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [4:0]          half_q, half_d;
    logic                dummy_q, dummy_d;
    logic [WORD_W-1:0]   tx_q, tx_d;
    logic [WORD_W-1:0]   rx_q, rx_d;
    logic                cs_n_q, cs_n_d;
    logic                sclk_q, sclk_d;
    logic                valid_q, valid_d;
    logic [SAMPLE_W-1:0] data_q, data_d;
    logic [CHAN_W-1:0]   chan_q, chan_d;
    logic                busy_q, busy_d;
    logic                in_frame;
    logic                rx_lead_unused;

    // The first result bit is a converter leading zero and is never reported.
    assign rx_lead_unused = rx_q[WORD_W-1];
    assign in_frame       = (state_q == FRAME) || (state_q == INIT_F);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        dummy_d = dummy_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        valid_d = 1'b0;
        data_d  = data_q;
        chan_d  = chan_q;

        // Capture during the first cycle of each SCLK high phase.
        if (in_frame && half_q[0] && (cnt_q == 8'd0)) begin
            rx_d = {rx_q[WORD_W-2:0], bus.ADC_DOUT};
        end

        case (state_q)
            INIT_Q, QUIET: begin
                if (cnt_q == QUIET_LAST) begin
                    cnt_d  = '0;
                    half_d = '0;
                    cs_n_d = 1'b0;
                    sclk_d = 1'b0;
                    if (state_q == QUIET) begin
                        tx_d    = ctrl_word(bus.chan, RANGE_BIT);
                        state_d = FRAME;
                    end else begin
                        tx_d    = '1;
                        state_d = INIT_F;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            INIT_F, FRAME: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (half_q == 5'd31) begin
                        cs_n_d = 1'b1;
                        sclk_d = 1'b1;
                        if (state_q == FRAME) begin
                            state_d = DONE;
                            valid_d = 1'b1;
                            data_d  = rx_d[SAMPLE_W-1:0];
                            chan_d  = rx_d[RES_CHAN_MSB:RES_CHAN_LSB];
                        end else if (dummy_q) begin
                            state_d = IDLE;
                        end else begin
                            state_d = INIT_Q;
                            dummy_d = 1'b1;
                        end
                    end else begin
                        half_d = half_q + 5'd1;
                        sclk_d = ~sclk_q;
                        // Falling SCLK edge: advance DIN; dummy frames refill with ones.
                        if (half_q[0]) begin
                            tx_d = {tx_q[WORD_W-2:0], (state_q == INIT_F)};
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            IDLE: begin
                if (bus.run) begin
                    state_d = QUIET;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = bus.run ? QUIET : IDLE;
            end
            default: begin
                state_d = INIT_Q;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d == QUIET) || (state_d == FRAME) || (state_d == DONE);
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q <= INIT_Q;
            cnt_q   <= '0;
            half_q  <= '0;
            dummy_q <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
            valid_q <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            dummy_q <= dummy_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.ADC_DIN      = tx_q[WORD_W-1];
    assign bus.ADC_CS_N     = cs_n_q;
    assign bus.ADC_SCLK     = sclk_q;
    assign bus.sample_valid = valid_q;
    assign bus.sample_data  = data_q;
    assign bus.sample_chan  = chan_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_adc_sampler.sv
// Directed bench for adc_sampler with a behavioural converter and pin monitor.
module tb_adc_sampler;

    logic clk = 1'b0;
    logic reset;

    adc_sampler_if bus_if();

    adc_sampler #(
        .SCLK_DIV  (2),
        .QUIET_CYC (4),
        .RANGE_BIT (1'b1)
    ) dut (
        .CLK   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Converter model: shifts adc_word out MSB first, changing on SCLK falling edges,
    // and records the DIN word seen on the 16 SCLK rising edges of each full frame.
    logic [15:0] adc_word = 16'h0000;
    logic [15:0] din_sh = 16'h0000;
    logic [15:0] words[$];
    int          valid_cyc[$];
    int          rise_cnt = 0, bit_idx = 15, ph_len = 0, ph_min = 1000, ph_max = 0;
    int          valid_cnt = 0, wide_cnt = 0, start_cnt = 0;
    logic        prev_cs = 1'b1, prev_sclk = 1'b1, prev_valid = 1'b0, first_din = 1'b0;

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            prev_cs         = 1'b1;
            prev_sclk       = 1'b1;
            prev_valid      = 1'b0;
            rise_cnt        = 0;
            bus_if.ADC_DOUT = 1'b0;
        end else begin
            if (prev_cs && !bus_if.ADC_CS_N) begin
                start_cnt++;
                rise_cnt        = 0;
                din_sh          = 16'h0000;
                bit_idx         = 15;
                ph_len          = 1;
                first_din       = bus_if.ADC_DIN;
                bus_if.ADC_DOUT = adc_word[bit_idx];
            end else if (!bus_if.ADC_CS_N) begin
                if (bus_if.ADC_SCLK == prev_sclk) begin
                    ph_len++;
                end else begin
                    if (ph_len < ph_min) ph_min = ph_len;
                    if (ph_len > ph_max) ph_max = ph_len;
                    ph_len = 1;
                    if (bus_if.ADC_SCLK) begin
                        rise_cnt++;
                        din_sh = {din_sh[14:0], bus_if.ADC_DIN};
                    end else if (bit_idx > 0) begin
                        bit_idx--;
                        bus_if.ADC_DOUT = adc_word[bit_idx];
                    end
                end
            end else if (!prev_cs) begin
                if (ph_len < ph_min) ph_min = ph_len;
                if (ph_len > ph_max) ph_max = ph_len;
                if (rise_cnt == 16) words.push_back(din_sh);
            end
            if (bus_if.sample_valid) begin
                valid_cnt++;
                valid_cyc.push_back(cyc);
                if (prev_valid) wide_cnt++;
            end
            prev_valid = bus_if.sample_valid;
            prev_cs    = bus_if.ADC_CS_N;
            prev_sclk  = bus_if.ADC_SCLK;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        bus_if.run  = 1'b0;
        bus_if.chan = 3'd0;
        repeat (3) step();
        n_cmp++; if (bus_if.ADC_CS_N !== 1'b1) begin n_bad++; $display("FAIL rst_cs_n: got %b want 1", bus_if.ADC_CS_N); end
        n_cmp++; if (bus_if.ADC_SCLK !== 1'b1) begin n_bad++; $display("FAIL rst_sclk: got %b want 1", bus_if.ADC_SCLK); end
        n_cmp++; if (bus_if.ADC_DIN !== 1'b0) begin n_bad++; $display("FAIL rst_din: got %b want 0", bus_if.ADC_DIN); end
        n_cmp++; if (bus_if.sample_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", bus_if.sample_valid); end
        n_cmp++; if (bus_if.sample_data !== 12'h000) begin n_bad++; $display("FAIL rst_data: got %h want 000", bus_if.sample_data); end
        n_cmp++; if (bus_if.sample_chan !== 3'd0) begin n_bad++; $display("FAIL rst_chan: got %0d want 0", bus_if.sample_chan); end
        n_cmp++; if (bus_if.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bus_if.busy); end
    endtask

    task automatic test_dummy_frames(input int w0);
        int t;
        bus_if.chan = 3'd5;
        bus_if.run  = 1'b1;
        adc_word    = 16'h3ABC;
        reset       = 1'b1;
        t = 0;
        while (words.size() < w0 + 2 && t < 400) begin step(); t++; end
        n_cmp++;
        if (words.size() < w0 + 2) begin
            n_bad++; $display("FAIL dummy_wait: got %0d frames want 2", words.size() - w0);
        end else begin
            n_cmp++; if (words[w0] !== 16'hFFFF) begin n_bad++; $display("FAIL dummy0_din: got %h want ffff", words[w0]); end
            n_cmp++; if (words[w0+1] !== 16'hFFFF) begin n_bad++; $display("FAIL dummy1_din: got %h want ffff", words[w0+1]); end
            n_cmp++; if (valid_cnt !== 0) begin n_bad++; $display("FAIL dummy_valid: got %0d pulses want 0", valid_cnt); end
        end
    endtask

    task automatic test_first_word(input int w0);
        int t;
        t = 0;
        while (words.size() < w0 + 3 && t < 200) begin step(); t++; end
        n_cmp++;
        if (words.size() < w0 + 3) begin
            n_bad++; $display("FAIL first_wait: got %0d frames want 3", words.size() - w0);
        end else begin
            n_cmp++; if (words[w0+2] !== 16'h8BB0) begin n_bad++; $display("FAIL ctrl_word_ch5: got %h want 8bb0", words[w0+2]); end
            n_cmp++; if (first_din !== 1'b1) begin n_bad++; $display("FAIL din_at_cs_fall: got %b want 1", first_din); end
        end
    endtask

    task automatic test_sample();
        int t;
        t = 0;
        while (valid_cnt < 1 && t < 100) begin step(); t++; end
        n_cmp++; if (bus_if.sample_valid !== 1'b1) begin n_bad++; $display("FAIL valid_high: got %b want 1", bus_if.sample_valid); end
        n_cmp++; if (bus_if.sample_chan !== 3'd3) begin n_bad++; $display("FAIL sample_chan: got %0d want 3", bus_if.sample_chan); end
        n_cmp++; if (bus_if.sample_data !== 12'hABC) begin n_bad++; $display("FAIL sample_data: got %h want abc", bus_if.sample_data); end
        step();
        n_cmp++; if (bus_if.sample_valid !== 1'b0) begin n_bad++; $display("FAIL valid_pulse: got %b want 0", bus_if.sample_valid); end
        n_cmp++; if (bus_if.sample_data !== 12'hABC) begin n_bad++; $display("FAIL data_hold: got %h want abc", bus_if.sample_data); end
    endtask

    task automatic test_period();
        int t, v0, s0;
        v0       = valid_cnt;
        s0       = start_cnt;
        adc_word = 16'h5123;
        t = 0;
        while ((start_cnt == s0 || rise_cnt < 6) && t < 100) begin step(); t++; end
        n_cmp++; if (bus_if.sample_data !== 12'hABC) begin n_bad++; $display("FAIL midframe_hold: got %h want abc", bus_if.sample_data); end
        n_cmp++; if (bus_if.sample_chan !== 3'd3) begin n_bad++; $display("FAIL midframe_chan: got %0d want 3", bus_if.sample_chan); end
        t = 0;
        while (valid_cnt < v0 + 2 && t < 300) begin step(); t++; end
        n_cmp++;
        if (valid_cnt < v0 + 2) begin
            n_bad++; $display("FAIL period_wait: got %0d pulses want %0d", valid_cnt, v0 + 2);
        end else begin
            n_cmp++; if (valid_cyc[v0] - valid_cyc[v0-1] !== 69) begin n_bad++; $display("FAIL period_a: got %0d want 69", valid_cyc[v0] - valid_cyc[v0-1]); end
            n_cmp++; if (valid_cyc[v0+1] - valid_cyc[v0] !== 69) begin n_bad++; $display("FAIL period_b: got %0d want 69", valid_cyc[v0+1] - valid_cyc[v0]); end
            n_cmp++; if (bus_if.sample_data !== 12'h123) begin n_bad++; $display("FAIL sample2_data: got %h want 123", bus_if.sample_data); end
            n_cmp++; if (bus_if.sample_chan !== 3'd5) begin n_bad++; $display("FAIL sample2_chan: got %0d want 5", bus_if.sample_chan); end
        end
        n_cmp++; if (ph_min !== 2) begin n_bad++; $display("FAIL sclk_phase_min: got %0d want 2", ph_min); end
        n_cmp++; if (ph_max !== 2) begin n_bad++; $display("FAIL sclk_phase_max: got %0d want 2", ph_max); end
        n_cmp++; if (wide_cnt !== 0) begin n_bad++; $display("FAIL valid_width: got %0d wide pulses want 0", wide_cnt); end
    endtask

    task automatic test_stop();
        int t, s0, s1, v0, w0;
        s0 = start_cnt;
        t = 0;
        while ((start_cnt == s0 || rise_cnt < 8) && t < 150) begin step(); t++; end
        w0 = words.size();
        v0 = valid_cnt;
        bus_if.run = 1'b0;
        t = 0;
        while (bus_if.busy !== 1'b0 && t < 200) begin step(); t++; end
        n_cmp++; if (bus_if.busy !== 1'b0) begin n_bad++; $display("FAIL stop_busy: got %b want 0", bus_if.busy); end
        n_cmp++; if (valid_cnt !== v0 + 1) begin n_bad++; $display("FAIL stop_valid: got %0d want %0d", valid_cnt, v0 + 1); end
        n_cmp++; if (words.size() !== w0 + 1) begin n_bad++; $display("FAIL stop_full_frame: got %0d want %0d", words.size(), w0 + 1); end
        n_cmp++; if (bus_if.ADC_CS_N !== 1'b1) begin n_bad++; $display("FAIL stop_cs_n: got %b want 1", bus_if.ADC_CS_N); end
        s1 = start_cnt;
        repeat (100) step();
        n_cmp++; if (start_cnt !== s1) begin n_bad++; $display("FAIL stop_idle: got %0d new frames want 0", start_cnt - s1); end
    endtask

    task automatic test_reset_mid();
        int t, s0, v0, w0;
        s0 = start_cnt;
        bus_if.run = 1'b1;
        t = 0;
        while ((start_cnt == s0 || rise_cnt < 10) && t < 150) begin step(); t++; end
        v0    = valid_cnt;
        reset = 1'b0;
        step();
        n_cmp++; if (bus_if.ADC_CS_N !== 1'b1) begin n_bad++; $display("FAIL abort_cs_n: got %b want 1", bus_if.ADC_CS_N); end
        n_cmp++; if (bus_if.ADC_SCLK !== 1'b1) begin n_bad++; $display("FAIL abort_sclk: got %b want 1", bus_if.ADC_SCLK); end
        n_cmp++; if (bus_if.sample_valid !== 1'b0) begin n_bad++; $display("FAIL abort_valid: got %b want 0", bus_if.sample_valid); end
        n_cmp++; if (bus_if.busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", bus_if.busy); end
        repeat (2) step();
        w0    = words.size();
        reset = 1'b1;
        t = 0;
        while (words.size() < w0 + 3 && t < 500) begin step(); t++; end
        n_cmp++;
        if (words.size() < w0 + 3) begin
            n_bad++; $display("FAIL rerun_wait: got %0d frames want 3", words.size() - w0);
        end else begin
            n_cmp++; if (words[w0] !== 16'hFFFF) begin n_bad++; $display("FAIL rerun_dummy0: got %h want ffff", words[w0]); end
            n_cmp++; if (words[w0+1] !== 16'hFFFF) begin n_bad++; $display("FAIL rerun_dummy1: got %h want ffff", words[w0+1]); end
            n_cmp++; if (words[w0+2] !== 16'h8BB0) begin n_bad++; $display("FAIL rerun_word: got %h want 8bb0", words[w0+2]); end
            n_cmp++; if (valid_cnt !== v0 + 1) begin n_bad++; $display("FAIL rerun_valid: got %0d want %0d", valid_cnt, v0 + 1); end
        end
    endtask

    task automatic test_chan_change();
        int t, s0, w0;
        bus_if.chan = 3'd2;
        s0 = start_cnt;
        t = 0;
        while (start_cnt == s0 && t < 100) begin step(); t++; end
        w0 = words.size();
        t = 0;
        while (rise_cnt < 4 && t < 100) begin step(); t++; end
        bus_if.chan = 3'd6;
        t = 0;
        while (words.size() < w0 + 2 && t < 300) begin step(); t++; end
        n_cmp++;
        if (words.size() < w0 + 2) begin
            n_bad++; $display("FAIL chan_wait: got %0d frames want 2", words.size() - w0);
        end else begin
            n_cmp++; if (words[w0] !== 16'h85B0) begin n_bad++; $display("FAIL ctrl_word_ch2: got %h want 85b0", words[w0]); end
            n_cmp++; if (words[w0+1] !== 16'h8DB0) begin n_bad++; $display("FAIL ctrl_word_ch6: got %h want 8db0", words[w0+1]); end
        end
    endtask

    initial begin
        test_reset();
        test_dummy_frames(words.size());
        test_first_word(0);
        test_sample();
        test_period();
        test_stop();
        test_reset_mid();
        test_chan_change();
        bus_if.run = 1'b0;
        repeat (4) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
